// File: rtl/irrigation_cycle_timer.sv
// Fill-then-clean irrigation sequencer: fills until the upper sensor trips (or times out),
// then counts a two-digit BCD clean period down with the drain open and strobes done.
module irrigation_cycle_timer #(
    parameter logic [3:0] CLEAN_TENS   = 4'd5,
    parameter logic [3:0] CLEAN_UNITS  = 4'd9,
    parameter logic [6:0] FILL_TIMEOUT = 7'd90
) (
    input  logic       clk,
    input  logic       pulse,
    input  logic       tick,
    input  logic       start,
    input  logic       Us,
    input  logic       alin,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       reach_zero,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CLEAN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [6:0] fill_cnt;
    logic [6:0] fill_cnt_nx;
    logic [3:0] tens_nx;
    logic [3:0] units_nx;

    logic fill_valve_nx;
    logic drain_valve_nx;
    logic reach_zero_nx;
    logic busy_nx;
    logic done_nx;
    logic fault_nx;

    logic run_tick;
    logic count_zero;
    logic fill_expire;

    // alin swallows a coincident tick: it is dropped, never deferred
    assign run_tick    = tick & ~alin;
    assign count_zero  = (sec_tens == 4'd0) && (sec_units == 4'd0);
    assign fill_expire = run_tick && (fill_cnt == FILL_TIMEOUT - 7'd1);

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk) begin : state_reg
        if (pulse) begin
            state       <= S_IDLE;
            fill_cnt    <= 7'd0;
            sec_tens    <= 4'd0;
            sec_units   <= 4'd0;
            fill_valve  <= 1'b0;
            drain_valve <= 1'b0;
            reach_zero  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            fill_cnt    <= fill_cnt_nx;
            sec_tens    <= tens_nx;
            sec_units   <= units_nx;
            fill_valve  <= fill_valve_nx;
            drain_valve <= drain_valve_nx;
            reach_zero  <= reach_zero_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            fault       <= fault_nx;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin : next_state_logic
        state_nx    = state;
        fill_cnt_nx = fill_cnt;
        tens_nx     = sec_tens;
        units_nx    = sec_units;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_FILL;
                    fill_cnt_nx = 7'd0;
                end
            end
            S_FILL: begin
                if (run_tick) begin
                    fill_cnt_nx = fill_cnt + 7'd1;
                end
                // the level sensor takes priority over a timeout on the same cycle
                if (Us) begin
                    state_nx = S_CLEAN;
                    tens_nx  = CLEAN_TENS;
                    units_nx = CLEAN_UNITS;
                end else if (fill_expire) begin
                    state_nx = S_FAULT;
                end
            end
            S_CLEAN: begin
                if (count_zero) begin
                    state_nx = S_DONE;
                end else if (run_tick) begin
                    if (sec_units == 4'd0) begin
                        units_nx = 4'd9;
                        tens_nx  = sec_tens - 4'd1;
                    end else begin
                        units_nx = sec_units - 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_FAULT: begin
                state_nx = S_FAULT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin : output_logic
        fill_valve_nx  = (state_nx == S_FILL) && !alin;
        drain_valve_nx = (state_nx == S_CLEAN) && !alin;
        reach_zero_nx  = (state_nx == S_CLEAN) && (tens_nx == 4'd0) && (units_nx == 4'd0);
        busy_nx        = (state_nx == S_FILL) || (state_nx == S_CLEAN) || (state_nx == S_DONE);
        done_nx        = (state_nx == S_DONE);
        fault_nx       = (state_nx == S_FAULT);
    end

endmodule

// File: tb/tb_irrigation_cycle_timer.sv
// Self-checking bench for irrigation_cycle_timer: directed scenarios plus a random run, both
// checked against an integer-seconds reference model (default and 00-load instances).
module tb_irrigation_cycle_timer;

    logic clk = 1'b0;
    logic pulse, tick, start, Us, alin;

    logic       fv0, dv0, rz0, b0, d0, f0;
    logic [3:0] t0, u0;
    logic       fv1, dv1, rz1, b1, d1, f1;
    logic [3:0] t1, u1;

    irrigation_cycle_timer dut (
        .clk(clk), .pulse(pulse), .tick(tick), .start(start), .Us(Us), .alin(alin),
        .fill_valve(fv0), .drain_valve(dv0), .sec_tens(t0), .sec_units(u0),
        .reach_zero(rz0), .busy(b0), .done(d0), .fault(f0)
    );

    irrigation_cycle_timer #(
        .CLEAN_TENS(4'd0), .CLEAN_UNITS(4'd0), .FILL_TIMEOUT(7'd5)
    ) dut_z (
        .clk(clk), .pulse(pulse), .tick(tick), .start(start), .Us(Us), .alin(alin),
        .fill_valve(fv1), .drain_valve(dv1), .sec_tens(t1), .sec_units(u1),
        .reach_zero(rz1), .busy(b1), .done(d1), .fault(f1)
    );

    always #5 clk = ~clk;

    wire [13:0] obs0 = {fv0, dv0, t0, u0, rz0, b0, d0, f0};
    wire [13:0] obs1 = {fv1, dv1, t1, u1, rz1, b1, d1, f1};

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_CLEAN = 2;
    localparam int PH_DONE  = 3;
    localparam int PH_FAULT = 4;

    int checks = 0;
    int errors = 0;

    // Model: phase, remaining clean seconds as a plain integer, fill ticks seen, last alin.
    int m_phase[2];
    int m_rem[2];
    int m_fill[2];
    bit m_alin[2];

    function automatic int load_secs(int i);
        return (i == 0) ? 59 : 0;
    endfunction

    function automatic int timeout_ticks(int i);
        return (i == 0) ? 90 : 5;
    endfunction

    task automatic model_step(input bit p, input bit s, input bit u, input bit t, input bit a);
        for (int i = 0; i < 2; i++) begin
            if (p) begin
                m_phase[i] = PH_IDLE;
                m_rem[i]   = 0;
                m_fill[i]  = 0;
            end else begin
                case (m_phase[i])
                    PH_IDLE: if (s) begin
                        m_phase[i] = PH_FILL;
                        m_fill[i]  = 0;
                    end
                    PH_FILL: begin
                        if (t && !a) m_fill[i]++;
                        if (u) begin
                            m_phase[i] = PH_CLEAN;
                            m_rem[i]   = load_secs(i);
                        end else if (m_fill[i] >= timeout_ticks(i)) begin
                            m_phase[i] = PH_FAULT;
                        end
                    end
                    PH_CLEAN: begin
                        if (m_rem[i] == 0) m_phase[i] = PH_DONE;
                        else if (t && !a) m_rem[i]--;
                    end
                    PH_DONE: m_phase[i] = PH_IDLE;
                    default: m_phase[i] = PH_FAULT;
                endcase
            end
            m_alin[i] = a;
        end
    endtask

    function automatic logic [13:0] expect_of(int i);
        logic [3:0] et, eu;
        et = 4'(m_rem[i] / 10);
        eu = 4'(m_rem[i] % 10);
        return {m_phase[i] == PH_FILL && !m_alin[i], m_phase[i] == PH_CLEAN && !m_alin[i], et, eu,
                m_phase[i] == PH_CLEAN && m_rem[i] == 0,
                m_phase[i] == PH_FILL || m_phase[i] == PH_CLEAN || m_phase[i] == PH_DONE,
                m_phase[i] == PH_DONE, m_phase[i] == PH_FAULT};
    endfunction

    // Drive one clock's inputs well away from the edge, advance the model, sample 1 ns later.
    task automatic cyc(input bit p, input bit s, input bit u, input bit t, input bit a);
        pulse = p; start = s; Us = u; tick = t; alin = a;
        @(posedge clk);
        model_step(p, s, u, t, a);
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 1, 1, 1, 0);
        checks++;
        if (obs0 !== 14'd0) begin
            errors++; $display("FAIL reset_default: got %h want %h", obs0, 14'd0);
        end
        checks++;
        if (obs1 !== 14'd0) begin
            errors++; $display("FAIL reset_zero_inst: got %h want %h", obs1, 14'd0);
        end
    endtask

    task automatic test_nominal;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        checks++;
        if ({fv0, b0} !== 2'b11) begin
            errors++; $display("FAIL nominal_fill_open: got fv/busy %b want 11", {fv0, b0});
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (obs0 !== expect_of(0)) begin
                errors++; $display("FAIL nominal_fill %0d: got %h want %h", k, obs0, expect_of(0));
            end
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if ({fv0, dv0, t0, u0} !== 10'b01_0101_1001) begin
            errors++; $display("FAIL nominal_load: got %b want 0101011001", {fv0, dv0, t0, u0});
        end
        for (int k = 0; k < 59; k++) begin
            cyc(0, 0, 0, 1, 0);
            checks++;
            if (obs0 !== expect_of(0)) begin
                errors++; $display("FAIL nominal_count %0d: got %h want %h", k, obs0, expect_of(0));
            end
            if (k < 58) cyc(0, 0, 0, 0, 0);
        end
        checks++;
        if ({rz0, d0, t0, u0} !== 10'b10_0000_0000) begin
            errors++; $display("FAIL nominal_reach_zero: got %b want 1000000000", {rz0, d0, t0, u0});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({d0, b0, rz0, dv0} !== 4'b1100) begin
            errors++; $display("FAIL nominal_done: got %b want 1100", {d0, b0, rz0, dv0});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (obs0 !== 14'd0) begin
            errors++; $display("FAIL nominal_idle: got %h want %h", obs0, 14'd0);
        end
    endtask

    task automatic test_fault;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 1; k <= 90; k++) begin
            cyc(0, 0, 0, 1, 0);
            if (k == 89) begin
                checks++;
                if ({f0, fv0} !== 2'b01) begin
                    errors++; $display("FAIL fault_early: got f/fv %b want 01", {f0, fv0});
                end
            end
        end
        checks++;
        if ({f0, fv0, dv0, b0} !== 4'b1000) begin
            errors++; $display("FAIL fault_enter: got %b want 1000", {f0, fv0, dv0, b0});
        end
        cyc(0, 1, 0, 0, 0);
        checks++;
        if ({f0, b0, fv0} !== 3'b100) begin
            errors++; $display("FAIL fault_start_ignored: got %b want 100", {f0, b0, fv0});
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (obs0 !== 14'd0) begin
            errors++; $display("FAIL fault_cleared: got %h want %h", obs0, 14'd0);
        end
    endtask

    task automatic test_alin;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int k = 0; k < 29; k++) cyc(0, 0, 0, 1, 0);
        checks++;
        if ({t0, u0} !== 8'h30) begin
            errors++; $display("FAIL alin_setup: got %h want 30", {t0, u0});
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 1);
            checks++;
            if ({t0, u0, dv0, b0} !== 10'b0011_0000_01) begin
                errors++; $display("FAIL alin_hold %0d: got %b want 0011000001", k, {t0, u0, dv0, b0});
            end
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if ({dv0, t0, u0} !== 9'b1_0011_0000) begin
            errors++; $display("FAIL alin_release: got %b want 100110000", {dv0, t0, u0});
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if ({t0, u0} !== 8'h29) begin
            errors++; $display("FAIL alin_borrow: got %h want 29", {t0, u0});
        end
    endtask

    task automatic test_coincident;
        cyc(0, 0, 0, 1, 1);
        checks++;
        if ({t0, u0, dv0} !== 9'b0010_1001_0) begin
            errors++; $display("FAIL coincident_tick_alin: got %b want 001010010", {t0, u0, dv0});
        end
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 89; k++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        checks++;
        if ({f0, dv0, fv0, t0, u0} !== 11'b010_0101_1001) begin
            errors++; $display("FAIL coincident_us_timeout: got %b want 01001011001", {f0, dv0, fv0, t0, u0});
        end
        checks++;
        if (obs0 !== expect_of(0)) begin
            errors++; $display("FAIL coincident_model: got %h want %h", obs0, expect_of(0));
        end
    endtask

    task automatic test_pulse_mid;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int k = 0; k < 47; k++) cyc(0, 0, 0, 1, 0);
        checks++;
        if ({t0, u0} !== 8'h12) begin
            errors++; $display("FAIL pulse_setup: got %h want 12", {t0, u0});
        end
        cyc(1, 0, 0, 1, 0);
        checks++;
        if (obs0 !== 14'd0) begin
            errors++; $display("FAIL pulse_discard: got %h want %h", obs0, 14'd0);
        end
        cyc(0, 1, 0, 0, 0);
        checks++;
        if ({fv0, b0, dv0} !== 3'b110) begin
            errors++; $display("FAIL pulse_restart: got %b want 110", {fv0, b0, dv0});
        end
    endtask

    task automatic test_zero_params;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if ({rz1, dv1, b1, d1, t1, u1} !== 12'b1110_0000_0000) begin
            errors++; $display("FAIL zero_entry: got %b want 111000000000", {rz1, dv1, b1, d1, t1, u1});
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if ({d1, rz1, dv1} !== 3'b100) begin
            errors++; $display("FAIL zero_done: got %b want 100", {d1, rz1, dv1});
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (obs1 !== 14'd0) begin
            errors++; $display("FAIL zero_idle: got %h want %h", obs1, 14'd0);
        end
    endtask

    task automatic test_random;
        bit p, s, u, t, a;
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            p = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 7) == 0);
            u = ($urandom_range(0, 59) == 0);
            t = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 9) == 0);
            cyc(p, s, u, t, a);
            checks++;
            if (obs0 !== expect_of(0)) begin
                errors++; $display("FAIL random_default %0d: got %h want %h", n, obs0, expect_of(0));
            end
            checks++;
            if (obs1 !== expect_of(1)) begin
                errors++; $display("FAIL random_zero %0d: got %h want %h", n, obs1, expect_of(1));
            end
        end
    endtask

    initial begin
        pulse = 1'b1; start = 1'b0; Us = 1'b0; tick = 1'b0; alin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_IDLE; m_rem[i] = 0; m_fill[i] = 0; m_alin[i] = 1'b0;
        end
        test_reset;
        test_nominal;
        test_fault;
        test_alin;
        test_coincident;
        test_pulse_mid;
        test_zero_params;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
